jump_control_unit: RTL and testbench
====================================

// Module: jump_control_unit
// PURPOSE
//  Moore FSM that sequences the datapath's control inputs for instruction fetch (T0-T2) and for the
//  control-transfer group (br, jr, jal, nop, halt). Replaces hand-driven testbench stepping.
//  Outputs connect one-to-one to the datapath control ports; ir and CONFFOut come back from the datapath.
// PARAMETERS
//  OP_BR 5'b10010 / OP_JR 5'b10011 / OP_JAL 5'b10100 / OP_NOP 5'b11010 / OP_HALT 5'b11011  opcode in ir[31:27]
//  PC_IN 20, MAR_IN 25, Z_IN 18, MDR_IN 21, IR_IN 24, Y_IN 19, CON_IN 23, LINK_IN 15   enable[] bit indices
//  PC_OUT 20, ZLO_OUT 19, MDR_OUT 21, C_OUT 23                                         busSelect[] bit indices
//  ALU_INCPC 5'd14, ALU_ADD 5'd3                                                       Control_Signals codes
// PORTS
//  clk              in   1   system clock, all state on rising edge
//  clr              in   1   reset, asynchronous, active-low
//  run              in   1   level; 1 = fetch/execute instructions
//  ir               in   32  datapath IR contents
//  CONFFOut         in   1   datapath branch-condition flip-flop
//  enable           out  32  register load enables (one-hot per bit index above)
//  busSelect        out  32  bus source select, at most one bit set
//  Control_Signals  out  5   ALU operation code
//  Gra Grb Grc Rin Rout BAout  out 1 each  select-and-encode controls
//  MD_Read ReadRAM WriteRAM    out 1 each  MDR source / RAM strobes (WriteRAM always 0 here)
//  halted           out  1   1 while in HALTED
//  illegal_op       out  1   1-cycle pulse in T3 when the opcode is not in the supported set
//  instr_count      out  16  number of decoded instructions, wraps 16'hFFFF->0
//  state_out        out  4   current state encoding (debug)
// BEHAVIOUR
//  States: IDLE=0, T0..T6=1..7, HALTED=8. One state per clock. All outputs are decoded only from
//   the state register (and ir/CONFFOut where noted); unlisted outputs are 0 in every state.
//  Reset (clr=0, async): state=IDLE, instr_count=0; every output 0 while clr=0 and in IDLE.
//  IDLE: all outputs 0; run=1 -> T0 at next edge.
//  T0: busSelect[PC_OUT], enable[MAR_IN], Control_Signals=ALU_INCPC, enable[Z_IN] -> T1.
//  T1: busSelect[ZLO_OUT], enable[PC_IN], enable[MDR_IN], MD_Read, ReadRAM -> T2.
//  T2: busSelect[MDR_OUT], enable[IR_IN] -> T3. ir holds the new instruction from the start of T3.
//  T3 (dispatch on ir[31:27]; instr_count+1 at the edge leaving T3):
//   JR : Gra, Rout, enable[PC_IN] -> fetch.
//   JAL: busSelect[PC_OUT], enable[LINK_IN] (R15<-PC+1) -> T4; T4: Gra, Rout, enable[PC_IN] -> fetch.
//   BR : Gra, Rout, enable[CON_IN] -> T4; T4: busSelect[PC_OUT], enable[Y_IN] -> T5;
//        T5: busSelect[C_OUT], Control_Signals=ALU_ADD, enable[Z_IN] -> T6;
//        T6: busSelect[ZLO_OUT]; enable[PC_IN]=CONFFOut (sampled in T6) -> fetch.
//   NOP: no controls -> fetch. HALT: no controls -> HALTED.
//   other opcode: illegal_op=1, otherwise treated as NOP.
//  "fetch" = T0 if run=1 at that edge, else IDLE. Dropping run mid-instruction completes the
//   current instruction, then stops at the fetch boundary. Fetch states never abort.
//  HALTED: halted=1, outputs otherwise 0; run=0 -> IDLE (run must go low, then high, to restart).
//  Latency: jr/nop 4 cycles, jal 5, br 7 (T0 entry to next T0 entry).
//  Async clr mid-instruction: immediate IDLE; no partial enables after the clr edge.
//  At most one busSelect bit and no conflicting PC_IN sources in any state.
// TESTING
//  1 reset: clr=0 in T1 -> enable=0, busSelect=0, MD_Read=0 immediately; state_out=0, instr_count=0.
//  2 jr: ir=OP_JR,Ra=R2 (R2=5), run=1 -> T0..T3 strobes exactly as above, PC=5, next T0 in cycle 5.
//  3 jal: ir=OP_JAL,Ra=R2, PC=13 -> R15=14 after T3, PC=R2 after T4, instr_count=1.
//  4 br: CONFFOut=1, PC=14, C=4 -> PC=18 after T6; repeat with CONFFOut=0 -> PC stays 14, no PC_IN in T6.
//  5 halt/illegal: ir=OP_HALT -> halted=1 until run=0; ir opcode 5'b11111 -> one illegal_op pulse, then fetch.
//  6 run=0 during BR T5 -> T6 completes, then IDLE; 65536 nops -> instr_count wraps to 0.

Source files
------------

// File: rtl/jump_control_unit.sv
// Control sequencer for instruction fetch (T0-T2) and the control-transfer group
// (br, jr, jal, nop, halt). Outputs are decoded from the state register (and from
// ir_i / conffout_i where an instruction needs them), so an asynchronous clear
// immediately returns every control to 0.
//
// Ports:
//   clk_i             system clock, rising edge
//   clr_ni            asynchronous active-low clear
//   run_i             level; 1 = keep fetching/executing
//   ir_i              datapath IR contents (opcode in [31:27])
//   conffout_i        datapath branch-condition flip-flop
//   enable_o          register load enables
//   bus_select_o      bus source select (at most one bit set)
//   control_signals_o ALU operation code
//   gra_o .. baout_o  select-and-encode controls
//   md_read_o, read_ram_o, write_ram_o  MDR source and RAM strobes
//   halted_o          1 while halted
//   illegal_op_o      1-cycle pulse in T3 for an unsupported opcode
//   instr_count_o     decoded instruction count (wraps)
//   state_out_o       current state encoding
module jump_control_unit (
    input  logic        clk_i,
    input  logic        clr_ni,
    input  logic        run_i,
    input  logic [31:0] ir_i,
    input  logic        conffout_i,
    output logic [31:0] enable_o,
    output logic [31:0] bus_select_o,
    output logic [4:0]  control_signals_o,
    output logic        gra_o,
    output logic        grb_o,
    output logic        grc_o,
    output logic        rin_o,
    output logic        rout_o,
    output logic        baout_o,
    output logic        md_read_o,
    output logic        read_ram_o,
    output logic        write_ram_o,
    output logic        halted_o,
    output logic        illegal_op_o,
    output logic [15:0] instr_count_o,
    output logic [3:0]  state_out_o
);

    localparam logic [4:0] OpBr   = 5'b10010;
    localparam logic [4:0] OpJr   = 5'b10011;
    localparam logic [4:0] OpJal  = 5'b10100;
    localparam logic [4:0] OpNop  = 5'b11010;
    localparam logic [4:0] OpHalt = 5'b11011;

    localparam int unsigned PcIn   = 20;
    localparam int unsigned MarIn  = 25;
    localparam int unsigned ZIn    = 18;
    localparam int unsigned MdrIn  = 21;
    localparam int unsigned IrIn   = 24;
    localparam int unsigned YIn    = 19;
    localparam int unsigned ConIn  = 23;
    localparam int unsigned LinkIn = 15;

    localparam int unsigned PcOut  = 20;
    localparam int unsigned ZloOut = 19;
    localparam int unsigned MdrOut = 21;
    localparam int unsigned COut   = 23;

    localparam logic [4:0] AluIncPc = 5'd14;
    localparam logic [4:0] AluAdd   = 5'd3;

    typedef enum logic [3:0] {
        StIdle   = 4'd0,
        StT0     = 4'd1,
        StT1     = 4'd2,
        StT2     = 4'd3,
        StT3     = 4'd4,
        StT4     = 4'd5,
        StT5     = 4'd6,
        StT6     = 4'd7,
        StHalted = 4'd8
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] count_q;
    logic [4:0]  opcode;
    state_e      fetch_st;

    assign opcode   = ir_i[31:27];
    // Instruction boundary: continue fetching only while run is held high.
    assign fetch_st = run_i ? StT0 : StIdle;

    always_ff @(posedge clk_i or negedge clr_ni) begin
        if (!clr_ni) begin
            state_q <= StIdle;
            count_q <= 16'd0;
        end else begin
            state_q <= state_d;
            if (state_q == StT3) begin
                count_q <= count_q + 16'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   state_d = run_i ? StT0 : StIdle;
            StT0:     state_d = StT1;
            StT1:     state_d = StT2;
            StT2:     state_d = StT3;
            StT3: begin
                if (opcode == OpJal || opcode == OpBr) begin
                    state_d = StT4;
                end else if (opcode == OpHalt) begin
                    state_d = StHalted;
                end else begin
                    state_d = fetch_st;
                end
            end
            // ir is stable through the execute states, so T4 re-decodes it.
            StT4:     state_d = (opcode == OpBr) ? StT5 : fetch_st;
            StT5:     state_d = StT6;
            StT6:     state_d = fetch_st;
            StHalted: state_d = run_i ? StHalted : StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        enable_o          = 32'd0;
        bus_select_o      = 32'd0;
        control_signals_o = 5'd0;
        gra_o             = 1'b0;
        grb_o             = 1'b0;
        grc_o             = 1'b0;
        rin_o             = 1'b0;
        rout_o            = 1'b0;
        baout_o           = 1'b0;
        md_read_o         = 1'b0;
        read_ram_o        = 1'b0;
        write_ram_o       = 1'b0;
        halted_o          = 1'b0;
        illegal_op_o      = 1'b0;
        unique case (state_q)
            StT0: begin
                bus_select_o[PcOut] = 1'b1;
                enable_o[MarIn]     = 1'b1;
                enable_o[ZIn]       = 1'b1;
                control_signals_o   = AluIncPc;
            end
            StT1: begin
                bus_select_o[ZloOut] = 1'b1;
                enable_o[PcIn]       = 1'b1;
                enable_o[MdrIn]      = 1'b1;
                md_read_o            = 1'b1;
                read_ram_o           = 1'b1;
            end
            StT2: begin
                bus_select_o[MdrOut] = 1'b1;
                enable_o[IrIn]       = 1'b1;
            end
            StT3: begin
                case (opcode)
                    OpJr: begin
                        gra_o          = 1'b1;
                        rout_o         = 1'b1;
                        enable_o[PcIn] = 1'b1;
                    end
                    OpJal: begin
                        bus_select_o[PcOut] = 1'b1;
                        enable_o[LinkIn]    = 1'b1;
                    end
                    OpBr: begin
                        gra_o           = 1'b1;
                        rout_o          = 1'b1;
                        enable_o[ConIn] = 1'b1;
                    end
                    OpNop, OpHalt: ;
                    default: illegal_op_o = 1'b1;
                endcase
            end
            StT4: begin
                if (opcode == OpJal) begin
                    gra_o          = 1'b1;
                    rout_o         = 1'b1;
                    enable_o[PcIn] = 1'b1;
                end else if (opcode == OpBr) begin
                    bus_select_o[PcOut] = 1'b1;
                    enable_o[YIn]       = 1'b1;
                end
            end
            StT5: begin
                bus_select_o[COut] = 1'b1;
                enable_o[ZIn]      = 1'b1;
                control_signals_o  = AluAdd;
            end
            StT6: begin
                bus_select_o[ZloOut] = 1'b1;
                enable_o[PcIn]       = conffout_i;
            end
            StHalted: halted_o = 1'b1;
            default: ;
        endcase
    end

    assign instr_count_o = count_q;
    assign state_out_o   = state_q;

endmodule

// File: tb/tb_jump_control_unit.sv
module tb_jump_control_unit;

    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_JR   = 5'b10011;
    localparam logic [4:0] OP_JAL  = 5'b10100;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;
    localparam logic [4:0] OP_BAD  = 5'b11111;

    localparam int PC_IN = 20, MAR_IN = 25, Z_IN = 18, MDR_IN = 21, IR_IN = 24;
    localparam int Y_IN = 19, CON_IN = 23, LINK_IN = 15;
    localparam int PC_OUT = 20, ZLO_OUT = 19, MDR_OUT = 21, C_OUT = 23;

    logic        clk = 1'b0;
    logic        clr_n;
    logic        run;
    logic        conff;
    logic [31:0] ir_q;

    logic [31:0] enable, bus_select;
    logic [4:0]  control_signals;
    logic        gra, grb, grc, rin, rout, baout, md_read, read_ram, write_ram;
    logic        halted, illegal_op;
    logic [15:0] instr_count;
    logic [3:0]  state_out;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    jump_control_unit dut (
        .clk_i            (clk),
        .clr_ni           (clr_n),
        .run_i            (run),
        .ir_i             (ir_q),
        .conffout_i       (conff),
        .enable_o         (enable),
        .bus_select_o     (bus_select),
        .control_signals_o(control_signals),
        .gra_o            (gra),
        .grb_o            (grb),
        .grc_o            (grc),
        .rin_o            (rin),
        .rout_o           (rout),
        .baout_o          (baout),
        .md_read_o        (md_read),
        .read_ram_o       (read_ram),
        .write_ram_o      (write_ram),
        .halted_o         (halted),
        .illegal_op_o     (illegal_op),
        .instr_count_o    (instr_count),
        .state_out_o      (state_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- small datapath driven by the DUT's controls ----------------
    logic [31:0] mem [64];
    logic [31:0] r [15];
    logic [31:0] r15, pc, mar, z, y, mdr;
    logic [31:0] pc_preset;
    logic        pc_load = 1'b0;
    logic [31:0] s_en, s_bus;
    logic [4:0]  s_cs;
    logic        s_gra, s_rout, s_mdrd;

    function automatic logic [31:0] reg_val(input logic [3:0] idx);
        return (idx == 4'd15) ? r15 : r[idx];
    endfunction

    function automatic logic [31:0] dp_bus();
        logic [31:0] b;
        b = 32'd0;
        if (s_gra && s_rout)     b = reg_val(ir_q[26:23]);
        else if (s_bus[PC_OUT])  b = pc;
        else if (s_bus[ZLO_OUT]) b = z;
        else if (s_bus[MDR_OUT]) b = mdr;
        else if (s_bus[C_OUT])   b = {{13{ir_q[18]}}, ir_q[18:0]};
        return b;
    endfunction

    always @(negedge clk) begin
        s_en   <= enable;
        s_bus  <= bus_select;
        s_cs   <= control_signals;
        s_gra  <= gra;
        s_rout <= rout;
        s_mdrd <= md_read;
    end

    always @(posedge clk) begin
        if (s_en[MAR_IN])  mar  <= dp_bus();
        if (s_en[Z_IN])    z    <= (s_cs == 5'd14) ? dp_bus() + 32'd1 :
                                   (s_cs == 5'd3)  ? y + dp_bus() : dp_bus();
        if (pc_load)       pc   <= pc_preset;
        else if (s_en[PC_IN]) pc <= dp_bus();
        if (s_en[MDR_IN])  mdr  <= s_mdrd ? mem[mar[5:0]] : dp_bus();
        if (s_en[IR_IN])   ir_q <= dp_bus();
        if (s_en[Y_IN])    y    <= dp_bus();
        if (s_en[LINK_IN]) r15  <= dp_bus();
    end

    // ---------------- behavioural model of the sequencer ----------------
    // m_st: 0 idle, 1..7 = cycle 0..6 of an instruction, 8 halted.
    logic [3:0]  m_st;
    logic [15:0] m_cnt;
    int          ill_cnt;

    typedef struct packed {
        logic [31:0] en;
        logic [31:0] bus;
        logic [4:0]  cs;
        logic        gra, rout, md_read, read_ram, halted, illegal;
    } exp_t;

    function automatic int instr_len(input logic [4:0] op);
        if (op == OP_BR)  return 7;
        if (op == OP_JAL) return 5;
        return 4;
    endfunction

    function automatic exp_t expect_ctrl(input logic [3:0] st, input logic [4:0] op,
                                         input logic cf);
        exp_t e;
        int   step;
        e = '0;
        if (st == 4'd8) begin
            e.halted = 1'b1;
        end else if (st == 4'd1) begin
            e.bus[PC_OUT] = 1'b1; e.en[MAR_IN] = 1'b1; e.en[Z_IN] = 1'b1; e.cs = 5'd14;
        end else if (st == 4'd2) begin
            e.bus[ZLO_OUT] = 1'b1; e.en[PC_IN] = 1'b1; e.en[MDR_IN] = 1'b1;
            e.md_read = 1'b1; e.read_ram = 1'b1;
        end else if (st == 4'd3) begin
            e.bus[MDR_OUT] = 1'b1; e.en[IR_IN] = 1'b1;
        end else if (st >= 4'd4 && st <= 4'd7) begin
            step = int'(st) - 4;
            if (op == OP_JR && step == 0) begin
                e.gra = 1'b1; e.rout = 1'b1; e.en[PC_IN] = 1'b1;
            end else if (op == OP_JAL && step == 0) begin
                e.bus[PC_OUT] = 1'b1; e.en[LINK_IN] = 1'b1;
            end else if (op == OP_JAL && step == 1) begin
                e.gra = 1'b1; e.rout = 1'b1; e.en[PC_IN] = 1'b1;
            end else if (op == OP_BR && step == 0) begin
                e.gra = 1'b1; e.rout = 1'b1; e.en[CON_IN] = 1'b1;
            end else if (op == OP_BR && step == 1) begin
                e.bus[PC_OUT] = 1'b1; e.en[Y_IN] = 1'b1;
            end else if (op == OP_BR && step == 2) begin
                e.bus[C_OUT] = 1'b1; e.en[Z_IN] = 1'b1; e.cs = 5'd3;
            end else if (op == OP_BR && step == 3) begin
                e.bus[ZLO_OUT] = 1'b1; e.en[PC_IN] = cf;
            end else if (step == 0 && op != OP_NOP && op != OP_HALT && op != OP_JR &&
                         op != OP_JAL && op != OP_BR) begin
                e.illegal = 1'b1;
            end
        end
        return e;
    endfunction

    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            m_st  <= 4'd0;
            m_cnt <= 16'd0;
        end else if (m_st == 4'd0) begin
            if (run) m_st <= 4'd1;
        end else if (m_st == 4'd8) begin
            if (!run) m_st <= 4'd0;
        end else begin
            if (m_st < 4'd4 || int'(m_st) < instr_len(ir_q[31:27])) m_st <= m_st + 4'd1;
            else if (ir_q[31:27] == OP_HALT) m_st <= 4'd8;
            else m_st <= run ? 4'd1 : 4'd0;
            if (m_st == 4'd4) m_cnt <= m_cnt + 16'd1;
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        exp_t e;
        e = expect_ctrl(m_st, ir_q[31:27], conff);
        check("enable", enable, e.en);
        check("busSelect", bus_select, e.bus);
        check("misc", {12'd0, control_signals, gra, grb, grc, rin, rout, baout, md_read,
                       read_ram, write_ram, halted, illegal_op, state_out},
                      {12'd0, e.cs, e.gra, 3'b000, e.rout, 1'b0, e.md_read, e.read_ram,
                       1'b0, e.halted, e.illegal, m_st});
        check("instr_count", {16'd0, instr_count}, {16'd0, m_cnt});
    end

    always @(negedge clk) begin
        if (!clr_n) ill_cnt <= 0;
        else if (illegal_op) ill_cnt <= ill_cnt + 1;
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_state(input logic [3:0] s, input int budget, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (state_out !== s && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (state_out !== s) begin
            checks++;
            failures++;
            $display("FAIL %s: timeout, state %0d required %0d", name, state_out, s);
        end
        #1;
    endtask

    task automatic reset_dut();
        @(posedge clk);
        #1 clr_n = 1'b0;
        run = 1'b0;
        @(posedge clk);
        #1 clr_n = 1'b1;
    endtask

    task automatic set_pc(input logic [31:0] v);
        pc_preset = v;
        pc_load = 1'b1;
        @(posedge clk);
        #1 pc_load = 1'b0;
    endtask

    initial begin
        int t0;
        for (int i = 0; i < 64; i++) mem[i] = {OP_NOP, 27'd0};
        for (int i = 0; i < 15; i++) r[i] = 32'd0;
        clr_n = 1'b0; run = 1'b0; conff = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {28'd0, state_out}, 32'd0);
        check("reset_count", {16'd0, instr_count}, 32'd0);
        #0 clr_n = 1'b1;

        // Async clear in the middle of T1 drops every strobe at once.
        set_pc(32'd0);
        run = 1'b1;
        wait_state(4'd2, 10, "reach_T1");
        #1 clr_n = 1'b0;
        #1;
        check("clr_enable", enable, 32'd0);
        check("clr_bus", bus_select, 32'd0);
        check("clr_md_read", {31'd0, md_read}, 32'd0);
        check("clr_state", {28'd0, state_out}, 32'd0);
        run = 1'b0;
        @(posedge clk);
        #1 clr_n = 1'b1;

        // jr R2 (R2 = 5): next T0 four cycles later with PC = 5.
        r[2] = 32'd5;
        mem[0] = {OP_JR, 4'd2, 23'd0};
        set_pc(32'd0);
        run = 1'b1;
        wait_state(4'd1, 10, "jr_T0");
        t0 = cyc;
        wait_state(4'd1, 10, "jr_next_T0");
        check("jr_latency", cyc - t0, 32'd4);
        check("jr_pc", pc, 32'd5);
        run = 1'b0;
        wait_state(4'd0, 10, "jr_idle");

        // jal R2 from PC 13: link = 14, PC = 40.
        reset_dut();
        r[2] = 32'd40;
        mem[13] = {OP_JAL, 4'd2, 23'd0};
        set_pc(32'd13);
        run = 1'b1;
        wait_state(4'd5, 10, "jal_T4");
        check("jal_link", r15, 32'd14);
        wait_state(4'd1, 10, "jal_next_T0");
        check("jal_pc", pc, 32'd40);
        check("jal_count", {16'd0, instr_count}, 32'd1);
        run = 1'b0;
        wait_state(4'd0, 10, "jal_idle");

        // br taken, with run dropped during T5: T6 still completes.
        reset_dut();
        mem[13] = {OP_BR, 4'd3, 4'd1, 19'd4};
        conff = 1'b1;
        set_pc(32'd13);
        run = 1'b1;
        wait_state(4'd6, 12, "br_T5");
        run = 1'b0;
        wait_state(4'd7, 3, "br_T6");
        check("br_T6_pc_in", {31'd0, enable[PC_IN]}, 32'd1);
        wait_state(4'd0, 3, "br_idle");
        check("br_taken_pc", pc, 32'd18);

        // br not taken.
        reset_dut();
        conff = 1'b0;
        set_pc(32'd13);
        run = 1'b1;
        wait_state(4'd1, 10, "brn_T0");
        run = 1'b0;
        wait_state(4'd7, 10, "brn_T6");
        check("brn_T6_pc_in", {31'd0, enable[PC_IN]}, 32'd0);
        wait_state(4'd0, 3, "brn_idle");
        check("brn_pc", pc, 32'd14);

        // halt: stays halted while run is high, idle once run drops.
        reset_dut();
        mem[0] = {OP_HALT, 27'd0};
        set_pc(32'd0);
        run = 1'b1;
        wait_state(4'd8, 10, "halt_enter");
        repeat (5) @(negedge clk);
        check("halt_hold", {31'd0, halted}, 32'd1);
        #1 run = 1'b0;
        wait_state(4'd0, 3, "halt_exit");
        check("halt_idle", {31'd0, halted}, 32'd0);

        // Illegal opcode: one pulse, then behaves as nop.
        reset_dut();
        mem[0] = {OP_BAD, 27'd0};
        set_pc(32'd0);
        run = 1'b1;
        wait_state(4'd1, 10, "ill_T0");
        wait_state(4'd1, 10, "ill_next_T0");
        run = 1'b0;
        wait_state(4'd0, 10, "ill_idle");
        check("ill_pulses", ill_cnt, 32'd1);
        check("ill_pc", pc, 32'd2);

        // Back-to-back nops advance the instruction count.
        reset_dut();
        set_pc(32'd30);
        run = 1'b1;
        for (int i = 0; i < 20; i++) wait_state(4'd1, 10, "nop_T0");
        run = 1'b0;
        wait_state(4'd0, 10, "nop_idle");
        check("nop_count", {16'd0, instr_count}, 32'd20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
